wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_pkg.sv | 9 +
 rtl/wb_fwd_match.sv | 30 +++
 rtl/wb_queue.sv | 70 +++++++
 tb/tb_wb_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and entry type for the writeback queue.
package wb_pkg;
   localparam int WB_DEPTH = 4;
   localparam logic [4:0] WB_XZR = 5'd31;
   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest-occupied-entry search for one operand index.
module wb_fwd_match
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter logic [4:0] XZR = WB_XZR
) (
   input  wb_entry_t [DEPTH-1:0]         entries,
   input  logic [DEPTH-1:0]              valid,
   input  logic [$clog2(DEPTH)-1:0]      head,
   input  logic [4:0]                    q,
   output logic                          hit,
   output logic [63:0]                   data
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0] idx;
   // Walk from oldest to youngest so the last match wins.
   always_comb begin
      hit = 1'b0;
      data = '0;
      idx = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (valid[idx] && entries[idx].rd == q && q != XZR) begin
            hit = 1'b1;
            data = entries[idx].data;
         end
      end
   end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: FIFO of pending register writebacks driving the register-file
// write port, with lookup of the youngest pending value for two operands.
module wb_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter logic [4:0] XZR = WB_XZR
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4:0]                 in_rd,
   input  logic [63:0]                in_data,
   input  logic                       hold,
   output logic [4:0]                 RdReg3,
   output logic [63:0]                DataWr,
   output logic                       RFWr,
   input  logic [4:0]                 q_rn,
   input  logic [4:0]                 q_rm,
   output logic                       fwd_rn_hit,
   output logic                       fwd_rm_hit,
   output logic [63:0]                fwd_rn_data,
   output logic [63:0]                fwd_rm_data,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   wb_entry_t [DEPTH-1:0] mem;
   logic [DEPTH-1:0] valid;
   logic [AW-1:0] rp, wp;
   logic push, pop, occ;
   always_comb begin
      occ = count != '0;
      in_ready = !rst && count < CW'(DEPTH);
      push = in_valid && in_ready && in_rd != XZR;
      RFWr = occ && !hold;
      pop = RFWr;
      RdReg3 = occ ? mem[rp].rd : '0;
      DataWr = occ ? mem[rp].data : '0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rp <= '0;
         wp <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
            valid[wp] <= 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
            valid[rp] <= 1'b0;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   // Storage is left unreset; the valid bits and count mask stale contents.
   always_ff @(posedge clk)
      if (push) mem[wp] <= '{rd: in_rd, data: in_data};
   wb_fwd_match #(.DEPTH(DEPTH), .XZR(XZR)) u_fwd_rn (
      .entries(mem), .valid(valid), .head(rp), .q(q_rn),
      .hit(fwd_rn_hit), .data(fwd_rn_data)
   );
   wb_fwd_match #(.DEPTH(DEPTH), .XZR(XZR)) u_fwd_rm (
      .entries(mem), .valid(valid), .head(rp), .q(q_rm),
      .hit(fwd_rm_hit), .data(fwd_rm_data)
   );
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed vector table plus hand sequences for wrap and reset.
module tb_wb_queue;
   typedef struct {
      logic        v;
      logic [4:0]  rd;
      logic [63:0] d;
      logic        h;
      logic [4:0]  qn;
      logic [4:0]  qm;
      logic        e_wr;
      logic [4:0]  e_rd;
      logic [63:0] e_d;
      logic [2:0]  e_cnt;
      logic        e_rdy;
      logic        e_nh;
      logic [63:0] e_nd;
      logic        e_mh;
      logic [63:0] e_md;
   } vec_t;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, hold, RFWr;
   logic fwd_rn_hit, fwd_rm_hit;
   logic [4:0] in_rd, RdReg3, q_rn, q_rm;
   logic [63:0] in_data, DataWr, fwd_rn_data, fwd_rm_data;
   logic [2:0] count;
   int n_chk = 0;
   int n_err = 0;
   vec_t tv[23];
   logic [4:0] mq_rd[$];
   logic [63:0] mq_d[$];

   always #5 clk = ~clk;

   wb_queue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_data(in_data), .hold(hold), .RdReg3(RdReg3),
      .DataWr(DataWr), .RFWr(RFWr), .q_rn(q_rn), .q_rm(q_rm),
      .fwd_rn_hit(fwd_rn_hit), .fwd_rm_hit(fwd_rm_hit),
      .fwd_rn_data(fwd_rn_data), .fwd_rm_data(fwd_rm_data), .count(count)
   );

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic v, logic [4:0] rd, logic [63:0] d, logic h);
      @(posedge clk);
      #1;
      in_valid = v;
      in_rd = rd;
      in_data = d;
      hold = h;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_rd = '0;
      in_data = '0;
      hold = 1'b0;
      q_rn = 5'd5;
      q_rm = '0;
      #2;
      chk("rst_count", count, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_rfwr", RFWr, 0);
      chk("rst_hit", fwd_rn_hit, 0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 chk("ready_after_rst", in_ready, 1);

      tv[0]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0};
      tv[1]  = '{1, 5, 64'hDEAD_BEEF, 0, 5, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0};
      tv[2]  = '{0, 0, 0, 0, 5, 0,   1, 5, 64'hDEAD_BEEF, 1, 1, 1, 64'hDEAD_BEEF, 0, 0};
      tv[3]  = '{0, 0, 0, 0, 5, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0};
      tv[4]  = '{1, 31, 7, 0, 31, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      tv[5]  = '{0, 0, 0, 0, 31, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0};
      tv[6]  = '{1, 1, 'h11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      tv[7]  = '{1, 2, 'h22, 1, 0, 0, 0, 1, 'h11, 1, 1, 0, 0, 0, 0};
      tv[8]  = '{1, 3, 'h33, 1, 0, 0, 0, 1, 'h11, 2, 1, 0, 0, 0, 0};
      tv[9]  = '{1, 4, 'h44, 1, 0, 0, 0, 1, 'h11, 3, 1, 0, 0, 0, 0};
      tv[10] = '{1, 6, 'h66, 1, 6, 0, 0, 1, 'h11, 4, 0, 0, 0, 0, 0};
      tv[11] = '{0, 0, 0, 1, 6, 2,   0, 1, 'h11, 4, 0, 0, 0, 1, 'h22};
      tv[12] = '{0, 0, 0, 0, 4, 1,   1, 1, 'h11, 4, 0, 1, 'h44, 1, 'h11};
      tv[13] = '{0, 0, 0, 0, 0, 0,   1, 2, 'h22, 3, 1, 0, 0, 0, 0};
      tv[14] = '{0, 0, 0, 0, 0, 0,   1, 3, 'h33, 2, 1, 0, 0, 0, 0};
      tv[15] = '{0, 0, 0, 0, 0, 0,   1, 4, 'h44, 1, 1, 0, 0, 0, 0};
      tv[16] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0};
      tv[17] = '{1, 9, 10, 1, 9, 31, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      tv[18] = '{1, 9, 20, 1, 9, 31, 0, 9, 10, 1, 1, 1, 10, 0, 0};
      tv[19] = '{0, 0, 0, 1, 9, 31,  0, 9, 10, 2, 1, 1, 20, 0, 0};
      tv[20] = '{0, 0, 0, 0, 9, 31,  1, 9, 10, 2, 1, 1, 20, 0, 0};
      tv[21] = '{0, 0, 0, 0, 9, 31,  1, 9, 20, 1, 1, 1, 20, 0, 0};
      tv[22] = '{0, 0, 0, 0, 9, 31,  0, 0, 0, 0, 1, 0, 0, 0, 0};

      foreach (tv[i]) begin
         @(posedge clk);
         #1;
         in_valid = tv[i].v;
         in_rd = tv[i].rd;
         in_data = tv[i].d;
         hold = tv[i].h;
         q_rn = tv[i].qn;
         q_rm = tv[i].qm;
         #1;
         chk($sformatf("v%0d_rfwr", i), RFWr, tv[i].e_wr);
         chk($sformatf("v%0d_rd", i), RdReg3, tv[i].e_rd);
         chk($sformatf("v%0d_data", i), DataWr, tv[i].e_d);
         chk($sformatf("v%0d_count", i), count, tv[i].e_cnt);
         chk($sformatf("v%0d_ready", i), in_ready, tv[i].e_rdy);
         chk($sformatf("v%0d_rn_hit", i), fwd_rn_hit, tv[i].e_nh);
         chk($sformatf("v%0d_rn_data", i), fwd_rn_data, tv[i].e_nd);
         chk($sformatf("v%0d_rm_hit", i), fwd_rm_hit, tv[i].e_mh);
         chk($sformatf("v%0d_rm_data", i), fwd_rm_data, tv[i].e_md);
      end

      q_rn = '0;
      q_rm = '0;
      drive(1, 5'd7, 64'h700, 1);
      mq_rd.push_back(5'd7);
      mq_d.push_back(64'h700);
      drive(1, 5'd8, 64'h800, 1);
      mq_rd.push_back(5'd8);
      mq_d.push_back(64'h800);
      for (int i = 0; i < 10; i++) begin
         drive(1, 5'(10 + i), 64'(100 + i), 0);
         #1;
         chk($sformatf("wrap%0d_rfwr", i), RFWr, 1);
         chk($sformatf("wrap%0d_rd", i), RdReg3, mq_rd[0]);
         chk($sformatf("wrap%0d_data", i), DataWr, mq_d[0]);
         chk($sformatf("wrap%0d_count", i), count, 2);
         void'(mq_rd.pop_front());
         void'(mq_d.pop_front());
         mq_rd.push_back(5'(10 + i));
         mq_d.push_back(64'(100 + i));
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0);
         #1;
         chk($sformatf("tail%0d_rfwr", i), RFWr, 1);
         chk($sformatf("tail%0d_rd", i), RdReg3, mq_rd[0]);
         chk($sformatf("tail%0d_data", i), DataWr, mq_d[0]);
         void'(mq_rd.pop_front());
         void'(mq_d.pop_front());
      end
      drive(0, 0, 0, 0);
      #1 chk("wrap_empty", count, 0);

      drive(1, 5'd21, 64'hA1, 1);
      drive(1, 5'd22, 64'hA2, 1);
      drive(1, 5'd23, 64'hA3, 1);
      drive(0, 0, 0, 0);
      q_rn = 5'd22;
      #1;
      chk("pre_rst_count", count, 3);
      chk("pre_rst_rfwr", RFWr, 1);
      chk("pre_rst_rd", RdReg3, 21);
      chk("pre_rst_hit", fwd_rn_hit, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_rfwr", RFWr, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_hit", fwd_rn_hit, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_count", count, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stale%0d_rfwr", i), RFWr, 0);
         chk($sformatf("stale%0d_hit", i), fwd_rn_hit, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
